// File: rtl/wb_pipeline.sv
// Write-back pipeline EX -> STAGES registers -> regfile, with stall/flush and forwarding.
// Define WB_PIPELINE_FWD_EN to build the forwarding comparators.
module wb_pipeline #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int STAGES     = 2,
   parameter int READ_PORTS = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ex_wreg,
   input  logic [ADDR_W-1:0]            ex_wd,
   input  logic [DATA_W-1:0]            ex_wdata,
   input  logic [STAGES:0]              stall,
   input  logic                         flush,
   input  logic [READ_PORTS*ADDR_W-1:0] fwd_raddr,
   output logic [READ_PORTS-1:0]        fwd_hit,
   output logic [READ_PORTS*DATA_W-1:0] fwd_data,
   output logic                         wb_wreg,
   output logic [ADDR_W-1:0]            wb_wd,
   output logic [DATA_W-1:0]            wb_wdata,
   output logic [$clog2(STAGES+2)-1:0]  pending_cnt
);

   localparam int CNT_W = $clog2(STAGES+2);

   logic [STAGES-1:0]             wreg_q, wreg_d;
   logic [STAGES-1:0][ADDR_W-1:0] wd_q, wd_d;
   logic [STAGES-1:0][DATA_W-1:0] data_q, data_d;

   logic [STAGES-1:0]             up_wreg;
   logic [STAGES-1:0][ADDR_W-1:0] up_wd;
   logic [STAGES-1:0][DATA_W-1:0] up_data;

   for (genvar k = 0; k < STAGES; k++) begin : g_up
      if (k == 0) begin : g_ex
         assign up_wreg[k] = ex_wreg;
         assign up_wd[k]   = ex_wd;
         assign up_data[k] = ex_wdata;
      end else begin : g_st
         assign up_wreg[k] = wreg_q[k-1];
         assign up_wd[k]   = wd_q[k-1];
         assign up_data[k] = data_q[k-1];
      end
   end

   // A stage whose upstream is stalled but which is itself free takes a bubble.
   always_comb begin
      wreg_d = wreg_q;
      wd_d   = wd_q;
      data_d = data_q;
      for (int k = 0; k < STAGES; k++) begin
         if (flush) begin
            wreg_d[k] = 1'b0;
            wd_d[k]   = '0;
            data_d[k] = '0;
         end else if (stall[k+1]) begin
            wreg_d[k] = wreg_q[k];
            wd_d[k]   = wd_q[k];
            data_d[k] = data_q[k];
         end else if (stall[k]) begin
            wreg_d[k] = 1'b0;
            wd_d[k]   = '0;
            data_d[k] = '0;
         end else begin
            wreg_d[k] = up_wreg[k];
            wd_d[k]   = up_wd[k];
            data_d[k] = up_data[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wreg_q <= '0;
         wd_q   <= '0;
         data_q <= '0;
      end else begin
         wreg_q <= wreg_d;
         wd_q   <= wd_d;
         data_q <= data_d;
      end
   end

   assign wb_wreg  = wreg_q[STAGES-1];
   assign wb_wd    = wd_q[STAGES-1];
   assign wb_wdata = data_q[STAGES-1];

   always_comb begin
      pending_cnt = '0;
      for (int k = 0; k < STAGES; k++)
         pending_cnt = pending_cnt + CNT_W'(wreg_q[k]);
   end

`ifdef WB_PIPELINE_FWD_EN
   logic [ADDR_W-1:0] ra;

   // Scan oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      fwd_hit  = '0;
      fwd_data = '0;
      ra       = '0;
      for (int p = 0; p < READ_PORTS; p++) begin
         ra = fwd_raddr[p*ADDR_W +: ADDR_W];
         if (ra != '0) begin
            for (int k = STAGES-1; k >= 0; k--) begin
               if (wreg_q[k] && wd_q[k] == ra) begin
                  fwd_hit[p]                 = 1'b1;
                  fwd_data[p*DATA_W +: DATA_W] = data_q[k];
               end
            end
            if (!stall[0] && ex_wreg && ex_wd == ra) begin
               fwd_hit[p]                 = 1'b1;
               fwd_data[p*DATA_W +: DATA_W] = ex_wdata;
            end
         end
      end
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^fwd_raddr;
   assign fwd_hit    = '0;
   assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_wb_pipeline.sv
// Directed self-checking bench for wb_pipeline at default parameters.
// Forwarding expectations follow WB_PIPELINE_FWD_EN.
module tb_wb_pipeline;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_wreg;
   logic [4:0]  ex_wd;
   logic [31:0] ex_wdata;
   logic [2:0]  stall;
   logic        flush;
   logic [9:0]  fwd_raddr;
   logic [1:0]  fwd_hit;
   logic [63:0] fwd_data;
   logic        wb_wreg;
   logic [4:0]  wb_wd;
   logic [31:0] wb_wdata;
   logic [1:0]  pending_cnt;

   int compared = 0;
   int mismatched = 0;

`ifdef WB_PIPELINE_FWD_EN
   localparam bit FE = 1'b1;
`else
   localparam bit FE = 1'b0;
`endif

   wb_pipeline dut (
      .clk(clk), .rst(rst),
      .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_wdata(ex_wdata),
      .stall(stall), .flush(flush),
      .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
      .pending_cnt(pending_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ex(input logic w, input logic [4:0] a,
                     input logic [31:0] d);
      ex_wreg  = w;
      ex_wd    = a;
      ex_wdata = d;
   endtask

   function automatic logic [1:0] eh(input logic [1:0] h);
      return FE ? h : 2'b00;
   endfunction

   function automatic logic [63:0] ed(input logic [31:0] d1,
                                      input logic [31:0] d0);
      return FE ? {d1, d0} : 64'h0;
   endfunction

   initial begin
      rst = 1'b1;
      ex(1'b0, 5'd0, 32'h0);
      stall = 3'b000;
      flush = 1'b0;
      fwd_raddr = {5'd3, 5'd3};
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_wreg", 64'(wb_wreg), 64'd0);
      chk("rst_wd", 64'(wb_wd), 64'd0);
      chk("rst_wdata", 64'(wb_wdata), 64'd0);
      chk("rst_cnt", 64'(pending_cnt), 64'd0);
      chk("rst_hit", 64'(fwd_hit), 64'd0);
      chk("rst_data", fwd_data, 64'd0);

      // single write, latency 2
      ex(1'b1, 5'd3, 32'hA5A5_0001);
      tick();
      ex(1'b0, 5'd0, 32'h0);
      #1;
      chk("s1_c1_wreg", 64'(wb_wreg), 64'd0);
      chk("s1_c1_cnt", 64'(pending_cnt), 64'd1);
      chk("s1_c1_hit", 64'(fwd_hit), 64'(eh(2'b11)));
      tick();
      chk("s1_wb_wreg", 64'(wb_wreg), 64'd1);
      chk("s1_wb_wd", 64'(wb_wd), 64'd3);
      chk("s1_wb_wdata", 64'(wb_wdata), 64'hA5A5_0001);
      tick();
      chk("s1_bub_wreg", 64'(wb_wreg), 64'd0);
      chk("s1_bub_cnt", 64'(pending_cnt), 64'd0);

      // back-to-back r4 writes
      ex(1'b1, 5'd4, 32'h11);
      tick();
      ex(1'b1, 5'd4, 32'h22);
      tick();
      chk("s2_wb11", 64'(wb_wdata), 64'h11);
      ex(1'b1, 5'd4, 32'h33);
      fwd_raddr = {5'd4, 5'd4};
      #1;
      chk("s2_ex_hit", 64'(fwd_hit), 64'(eh(2'b11)));
      chk("s2_ex_data", fwd_data, ed(32'h33, 32'h33));
      ex_wreg = 1'b0;
      #1;
      chk("s2_st0_data", fwd_data, ed(32'h22, 32'h22));
      ex_wreg = 1'b1;
      stall = 3'b001;
      #1;
      chk("s2_exstall_data", fwd_data, ed(32'h22, 32'h22));
      stall = 3'b000;
      fwd_raddr = {5'd9, 5'd4};
      #1;
      chk("s2_indep_hit", 64'(fwd_hit), 64'(eh(2'b01)));
      chk("s2_indep_data", fwd_data, ed(32'h0, 32'h33));
      fwd_raddr = {5'd4, 5'd4};
      tick();
      ex(1'b0, 5'd0, 32'h0);
      #1;
      chk("s2_wb22", 64'(wb_wdata), 64'h22);
      chk("s2_fwd33", fwd_data, ed(32'h33, 32'h33));
      tick();
      chk("s2_wb33", 64'(wb_wdata), 64'h33);
      chk("s2_wb33_wreg", 64'(wb_wreg), 64'd1);
      chk("s2_cnt1", 64'(pending_cnt), 64'd1);
      tick();
      chk("s2_empty", 64'(pending_cnt), 64'd0);

      // stall 3'b011 with r7 in stage 0
      ex(1'b1, 5'd7, 32'h77);
      tick();
      ex(1'b0, 5'd0, 32'h0);
      stall = 3'b011;
      fwd_raddr = {5'd7, 5'd7};
      tick();
      chk("s3_st1_wreg", 64'(wb_wreg), 64'd0);
      chk("s3_st1_cnt", 64'(pending_cnt), 64'd1);
      tick();
      chk("s3_st2_wreg", 64'(wb_wreg), 64'd0);
      chk("s3_st2_cnt", 64'(pending_cnt), 64'd1);
      chk("s3_st2_fwd", fwd_data, ed(32'h77, 32'h77));
      stall = 3'b000;
      tick();
      chk("s3_rel_wreg", 64'(wb_wreg), 64'd1);
      chk("s3_rel_wd", 64'(wb_wd), 64'd7);
      chk("s3_rel_wdata", 64'(wb_wdata), 64'h77);
      tick();
      chk("s3_empty", 64'(pending_cnt), 64'd0);

      // flush wins over full stall
      ex(1'b1, 5'd2, 32'h2222);
      tick();
      ex(1'b1, 5'd9, 32'h9999);
      tick();
      ex(1'b0, 5'd0, 32'h0);
      fwd_raddr = {5'd9, 5'd2};
      #1;
      chk("s4_cnt2", 64'(pending_cnt), 64'd2);
      chk("s4_pre_data", fwd_data, ed(32'h9999, 32'h2222));
      flush = 1'b1;
      stall = 3'b111;
      tick();
      flush = 1'b0;
      stall = 3'b000;
      #1;
      chk("s4_cnt0", 64'(pending_cnt), 64'd0);
      chk("s4_wreg", 64'(wb_wreg), 64'd0);
      chk("s4_hit", 64'(fwd_hit), 64'd0);

      // reset during stall
      ex(1'b1, 5'd5, 32'h55);
      tick();
      ex(1'b0, 5'd0, 32'h0);
      stall = 3'b111;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      stall = 3'b000;
      #1;
      chk("s4r_cnt0", 64'(pending_cnt), 64'd0);
      chk("s4r_wreg", 64'(wb_wreg), 64'd0);

      // r0 never forwards but still writes back
      ex(1'b1, 5'd0, 32'hFFFF_FFFF);
      tick();
      fwd_raddr = {5'd0, 5'd0};
      #1;
      chk("s5_hit", 64'(fwd_hit), 64'd0);
      chk("s5_data", fwd_data, 64'd0);
      ex(1'b0, 5'd0, 32'h0);
      tick();
      chk("s5_wb_wreg", 64'(wb_wreg), 64'd1);
      chk("s5_wb_wd", 64'(wb_wd), 64'd0);
      chk("s5_wb_wdata", 64'(wb_wdata), 64'hFFFF_FFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
